histogram_sequencer: RTL and testbench

HISTOGRAM_SEQUENCER -- requirements
Module: histogram_sequencer

---
 rtl/histogram_sequencer.sv | 269 ++++++++++++++++++++++++++
 tb/tb_histogram_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/histogram_sequencer.sv
// ---------------------------------------------------------------------------
// histogram_sequencer
//
// Steps a WIN_WIDTH x WIN_HEIGHT detection window across a video frame in a
// raster grid of STEP_X / STEP_Y. For each window it:
//   1. clears the histogram datapath (hist_reset high for CLEAR_CYCLES),
//   2. waits for a frame start (vsync) so the window begins on a frame,
//   3. gates the incoming pixel DE to the datapath while the frame position
//      lies inside the window,
//   4. drains the datapath until EXPECTED_WORDS histogram words have been
//      seen, or gives up after DRAIN_TIMEOUT cycles (sticky timeout),
//   5. pulses window_done, advances the origin, and repeats. After the last
//      grid position scan_done pulses and the scan either restarts
//      (continuous=1) or returns to idle.
//
// The gated DE is registered, so hist_de lags de_in by one cycle. The pixel
// bus feeding the histogram datapath has to be registered once alongside it
// so that data and strobe stay aligned. Because of that latency the strobe
// for the final window pixel lands on the first DRAIN cycle.
//
// Ports
//   pclk, reset_n      clock, asynchronous active-low reset
//   start              pulse: begin a scan (ignored unless idle)
//   continuous         restart the scan automatically after the last window
//   vsync              frame start: zeroes the frame coordinates
//   de_in              pixel data enable of the incoming frame
//   hist_de_out        word valid from the histogram datapath
//   fifo_full          histogram FIFO full
//   hist_de            gated, registered DE to the histogram datapath
//   hist_reset         synchronous clear to the histogram datapath
//   win_x, win_y       current window origin in pixels
//   window_done        pulse: current window's histogram complete
//   scan_done          pulse: last window of the grid complete
//   busy               FSM not idle
//   overflow, timeout  sticky error flags (cleared by an accepted start)
// ---------------------------------------------------------------------------
module histogram_sequencer #(
  parameter int FRAME_WIDTH    = 640,
  parameter int FRAME_HEIGHT   = 480,
  parameter int WIN_WIDTH      = 64,
  parameter int WIN_HEIGHT     = 128,
  parameter int STEP_X         = 8,
  parameter int STEP_Y         = 8,
  parameter int EXPECTED_WORDS = 1152,
  parameter int CLEAR_CYCLES   = 4,
  parameter int DRAIN_TIMEOUT  = 4096
) (
  input  logic        pclk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        continuous,
  input  logic        vsync,
  input  logic        de_in,
  input  logic        hist_de_out,
  input  logic        fifo_full,
  output logic        hist_de,
  output logic        hist_reset,
  output logic [10:0] win_x,
  output logic [10:0] win_y,
  output logic        window_done,
  output logic        scan_done,
  output logic        busy,
  output logic        overflow,
  output logic        timeout
);

  localparam int CLR_W  = (CLEAR_CYCLES  > 1) ? $clog2(CLEAR_CYCLES)  : 1;
  localparam int TO_W   = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam int STAGES = 1;  // latency of the gated DE

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_DRAIN,
    S_CLEAR
  } state_e;

  state_e             state_q, state_d;
  logic [10:0]        fx_q, fx_d, fy_q, fy_d;
  logic [10:0]        win_x_q, win_x_d, win_y_q, win_y_d;
  logic [11:0]        word_cnt_q, word_cnt_d;
  logic [CLR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [TO_W-1:0]    drain_cnt_q, drain_cnt_d;
  logic               win_done_q, scan_done_q;
  logic               overflow_q, overflow_d;
  logic               timeout_q, timeout_d;
  logic               rst_pend_q, rst_pend_d;
  logic [STAGES:0]    vld_pipe;

  logic               done_evt, to_evt, start_acc;
  logic               in_win, last_px;
  logic [11:0]        x_end, y_end, nx, ny;
  logic               wrap_x, wrap_y, last_win;

  // -------------------------------------------------------------------------
  // Frame coordinates. vsync wins over de_in in the same cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    fx_d = fx_q;
    fy_d = fy_q;
    if (vsync) begin
      fx_d = '0;
      fy_d = '0;
    end else if (de_in) begin
      if (fx_q == 11'(FRAME_WIDTH - 1)) begin
        fx_d = '0;
        fy_d = fy_q + 11'd1;
      end else begin
        fx_d = fx_q + 11'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Window geometry. Sums are carried at 12 bits so origin + size can never
  // wrap the 11-bit coordinate space.
  // -------------------------------------------------------------------------
  assign x_end   = {1'b0, win_x_q} + 12'(WIN_WIDTH);
  assign y_end   = {1'b0, win_y_q} + 12'(WIN_HEIGHT);
  assign in_win  = ({1'b0, fx_q} >= {1'b0, win_x_q}) && ({1'b0, fx_q} < x_end) &&
                   ({1'b0, fy_q} >= {1'b0, win_y_q}) && ({1'b0, fy_q} < y_end);
  assign last_px = ({1'b0, fx_q} == x_end - 12'd1) && ({1'b0, fy_q} == y_end - 12'd1);

  // Next grid position: step right, wrap to the next row band when the
  // window would stick out of the frame, and flag the end of the grid when
  // the row band would too.
  assign nx       = {1'b0, win_x_q} + 12'(STEP_X);
  assign ny       = {1'b0, win_y_q} + 12'(STEP_Y);
  assign wrap_x   = (nx + 12'(WIN_WIDTH)) > 12'(FRAME_WIDTH);
  assign wrap_y   = ny > 12'(FRAME_HEIGHT - WIN_HEIGHT);
  assign last_win = wrap_x && wrap_y;

  // -------------------------------------------------------------------------
  // FSM next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = '0;
    drain_cnt_d = '0;
    done_evt    = 1'b0;
    to_evt      = 1'b0;
    start_acc   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (clr_cnt_q == CLR_W'(CLEAR_CYCLES - 1)) state_d = S_ARM;
        else                                       clr_cnt_d = clr_cnt_q + 1'b1;
      end
      S_ARM: begin
        if (vsync) state_d = S_RUN;
      end
      S_RUN: begin
        if (de_in && last_px) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (word_cnt_q == 12'(EXPECTED_WORDS)) begin
          done_evt = 1'b1;
        end else if (drain_cnt_q == TO_W'(DRAIN_TIMEOUT - 1)) begin
          done_evt = 1'b1;
          to_evt   = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // End of grid without continuous mode skips the clear and idles.
    if (done_evt) state_d = (last_win && !continuous) ? S_IDLE : S_CLEAR;
  end

  // -------------------------------------------------------------------------
  // Datapath next state
  // -------------------------------------------------------------------------
  always_comb begin
    win_x_d    = win_x_q;
    win_y_d    = win_y_q;
    word_cnt_d = word_cnt_q;
    overflow_d = overflow_q;
    timeout_d  = timeout_q;
    rst_pend_d = rst_pend_q;

    if (state_q == S_CLEAR)
      word_cnt_d = '0;
    else if (hist_de_out && (state_q == S_RUN || state_q == S_DRAIN))
      word_cnt_d = word_cnt_q + 12'd1;

    if (start_acc) begin
      win_x_d    = '0;
      win_y_d    = '0;
      overflow_d = 1'b0;
      timeout_d  = 1'b0;
    end else begin
      if (fifo_full && vld_pipe[STAGES]) overflow_d = 1'b1;
      if (to_evt)                        timeout_d  = 1'b1;
    end

    if (done_evt) begin
      if (!wrap_x) begin
        win_x_d = nx[10:0];
      end else begin
        win_x_d = '0;
        win_y_d = wrap_y ? 11'd0 : ny[10:0];
      end
    end

    // The post-reset clear request holds until a CLEAR has run to the end.
    if (state_q == S_CLEAR && state_d != S_CLEAR) rst_pend_d = 1'b0;
  end

  // Gated DE: stage 0 is the combinational gate, stage STAGES drives hist_de.
  assign vld_pipe[0] = (state_q == S_RUN) && de_in && in_win;

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q            <= S_IDLE;
      fx_q               <= '0;
      fy_q               <= '0;
      win_x_q            <= '0;
      win_y_q            <= '0;
      word_cnt_q         <= '0;
      clr_cnt_q          <= '0;
      drain_cnt_q        <= '0;
      win_done_q         <= 1'b0;
      scan_done_q        <= 1'b0;
      overflow_q         <= 1'b0;
      timeout_q          <= 1'b0;
      rst_pend_q         <= 1'b1;
      vld_pipe[STAGES:1] <= '0;
    end else begin
      state_q            <= state_d;
      fx_q               <= fx_d;
      fy_q               <= fy_d;
      win_x_q            <= win_x_d;
      win_y_q            <= win_y_d;
      word_cnt_q         <= word_cnt_d;
      clr_cnt_q          <= clr_cnt_d;
      drain_cnt_q        <= drain_cnt_d;
      win_done_q         <= done_evt;
      scan_done_q        <= done_evt && last_win;
      overflow_q         <= overflow_d;
      timeout_q          <= timeout_d;
      rst_pend_q         <= rst_pend_d;
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign hist_de     = vld_pipe[STAGES];
  assign hist_reset  = rst_pend_q || (state_q == S_CLEAR);
  assign win_x       = win_x_q;
  assign win_y       = win_y_q;
  assign window_done = win_done_q;
  assign scan_done   = scan_done_q;
  assign busy        = (state_q != S_IDLE);
  assign overflow    = overflow_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_histogram_sequencer.sv
// Bench for histogram_sequencer on a reduced 32x16 frame with an 8x4 window
// stepping 8/4 (a 4x4 grid), 10 words per window, 64-cycle drain timeout.
module tb_histogram_sequencer;

  localparam int FW = 32, FH = 16, WW = 8, WH = 4, SX = 8, SY = 4;
  localparam int EW = 10, CC = 4, DT = 64;

  logic        pclk = 1'b0;
  logic        reset_n, start, continuous, vsync, de_in, hist_de_out, fifo_full;
  logic        hist_de, hist_reset, window_done, scan_done, busy, overflow, timeout;
  logic [10:0] win_x, win_y;

  histogram_sequencer #(
    .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .WIN_WIDTH(WW), .WIN_HEIGHT(WH),
    .STEP_X(SX), .STEP_Y(SY), .EXPECTED_WORDS(EW), .CLEAR_CYCLES(CC),
    .DRAIN_TIMEOUT(DT)
  ) dut (
    .pclk(pclk), .reset_n(reset_n), .start(start), .continuous(continuous),
    .vsync(vsync), .de_in(de_in), .hist_de_out(hist_de_out), .fifo_full(fifo_full),
    .hist_de(hist_de), .hist_reset(hist_reset), .win_x(win_x), .win_y(win_y),
    .window_done(window_done), .scan_done(scan_done), .busy(busy),
    .overflow(overflow), .timeout(timeout)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(negedge pclk) cyc <= cyc + 1;

  int n_chk = 0, n_err = 0;

  // One window: origin, words returned, fifo_full during the frame, a vsync
  // 40 pixels in, a start pulse 100 pixels in, and what must be seen on the
  // window_done cycle.
  typedef struct {
    int ox, oy, words;
    bit ff, vs, st;
    int ex_x, ex_y;
    bit ex_scan, ex_to, ex_ov, ex_busy;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_arm();
    int n = 0;
    while (hist_reset === 1'b1 && n < 50) begin
      n++;
      @(negedge pclk);
    end
    chk("clear_cycles", n, CC);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge pclk);
    start = 1'b0;
    chk("start_clears_overflow", overflow, 0);
    chk("start_clears_timeout", timeout, 0);
    wait_arm();
  endtask

  task automatic run_window(input vec_t v);
    int tfx, tfy, nde, mism, t_last, lx, ly, p;
    bit exp_de, last, vs_done, seen;
    lx = v.ox + WW - 1; ly = v.oy + WH - 1;
    tfx = 0; tfy = 0; nde = 0; mism = 0; p = 0; t_last = 0;
    exp_de = 0; last = 0; vs_done = 0; seen = 0;
    vsync = 1'b1;
    @(negedge pclk);
    vsync = 1'b0;
    fifo_full = v.ff;
    while (!last) begin
      if (hist_de !== exp_de) mism++;
      if (hist_de === 1'b1) nde++;
      start = 1'b0; vsync = 1'b0;
      if (v.vs && !vs_done && p == 40) begin
        vs_done = 1; vsync = 1'b1; de_in = 1'b0;
        exp_de = 0; tfx = 0; tfy = 0; p = 0;
      end else begin
        de_in = 1'b1;
        start = v.st && (p == 100);
        exp_de = (tfx >= v.ox) && (tfx < v.ox + WW) && (tfy >= v.oy) && (tfy < v.oy + WH);
        if (tfx == lx && tfy == ly) begin last = 1; t_last = cyc; end
        tfx++;
        if (tfx == FW) begin tfx = 0; tfy++; end
        p++;
      end
      @(negedge pclk);
    end
    if (hist_de !== exp_de) mism++;
    if (hist_de === 1'b1) nde++;
    de_in = 1'b0; start = 1'b0; fifo_full = 1'b0;
    chk("gate_mismatches", mism, 0);
    chk("gated_pixels", nde, WW * WH + (v.vs ? 16 : 0));
    for (int k = 0; k < v.words; k++) begin
      hist_de_out = 1'b1;
      @(negedge pclk);
    end
    hist_de_out = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (window_done === 1'b1) begin seen = 1; break; end
      @(negedge pclk);
    end
    chk("window_done_seen", seen, 1);
    if (seen) begin
      chk("win_x", win_x, v.ex_x);
      chk("win_y", win_y, v.ex_y);
      chk("scan_done", scan_done, v.ex_scan);
      chk("timeout", timeout, v.ex_to);
      chk("overflow", overflow, v.ex_ov);
      chk("busy", busy, v.ex_busy);
      if (v.words < EW) chk("drain_cycles", cyc - t_last, DT + 1);
      if (v.ex_busy) wait_arm();
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t r;
    reset_n = 1'b0; start = 1'b0; continuous = 1'b0; vsync = 1'b0;
    de_in = 1'b0; hist_de_out = 1'b0; fifo_full = 1'b0;

    //          ox  oy  wd  ff vs st  ex_x ex_y scan to ov busy
    tbl[0]  = '{ 0,  0, 10, 0, 1, 0,   8,  0,  0,  0, 0, 1};
    tbl[1]  = '{ 8,  0,  5, 0, 0, 0,  16,  0,  0,  1, 0, 1};
    tbl[2]  = '{16,  0, 10, 0, 0, 0,  24,  0,  0,  1, 0, 1};
    tbl[3]  = '{24,  0, 10, 1, 0, 0,   0,  4,  0,  1, 1, 1};
    tbl[4]  = '{ 0,  4, 10, 0, 0, 0,   8,  4,  0,  1, 1, 1};
    tbl[5]  = '{ 8,  4, 10, 0, 0, 1,  16,  4,  0,  1, 1, 1};
    tbl[6]  = '{16,  4, 10, 0, 0, 0,  24,  4,  0,  1, 1, 1};
    tbl[7]  = '{24,  4, 10, 0, 0, 0,   0,  8,  0,  1, 1, 1};
    tbl[8]  = '{ 0,  8, 10, 0, 0, 0,   8,  8,  0,  1, 1, 1};
    tbl[9]  = '{ 8,  8, 10, 0, 0, 0,  16,  8,  0,  1, 1, 1};
    tbl[10] = '{16,  8, 10, 0, 0, 0,  24,  8,  0,  1, 1, 1};
    tbl[11] = '{24,  8, 10, 0, 0, 0,   0, 12,  0,  1, 1, 1};
    tbl[12] = '{ 0, 12, 10, 0, 0, 0,   8, 12,  0,  1, 1, 1};
    tbl[13] = '{ 8, 12, 10, 0, 0, 0,  16, 12,  0,  1, 1, 1};
    tbl[14] = '{16, 12, 10, 0, 0, 0,  24, 12,  0,  1, 1, 1};
    tbl[15] = '{24, 12, 10, 0, 0, 0,   0,  0,  1,  1, 1, 0};

    repeat (3) @(negedge pclk);
    chk("rst_hist_de", hist_de, 0);
    chk("rst_hist_reset", hist_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_win_x", win_x, 0);
    chk("rst_win_y", win_y, 0);
    chk("rst_flags", {window_done, scan_done, overflow, timeout}, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge pclk);
    chk("hist_reset_held_idle", hist_reset, 1);

    // Scan 0 stops after the grid; scan 1 runs continuously and wraps.
    for (int s = 0; s < 2; s++) begin
      continuous = (s == 1);
      do_start();
      for (int i = 0; i < 16; i++) begin
        r = tbl[i];
        if (i == 15) r.ex_busy = (s == 1);
        run_window(r);
      end
    end

    // Continuous wrap: first window of the next pass, sticky flags still set.
    r = '{0, 0, 10, 0, 0, 0, 8, 0, 0, 1, 1, 1};
    run_window(r);

    // Reset in the middle of window (8,0) while hist_de is high.
    vsync = 1'b1;
    @(negedge pclk);
    vsync = 1'b0;
    for (int x = 0; x <= 10; x++) begin
      de_in = 1'b1;
      @(negedge pclk);
    end
    chk("pre_reset_hist_de", hist_de, 1);
    reset_n = 1'b0;
    #1;
    chk("midrun_rst_hist_de", hist_de, 0);
    chk("midrun_rst_hist_reset", hist_reset, 1);
    chk("midrun_rst_busy", busy, 0);
    chk("midrun_rst_win_x", win_x, 0);
    chk("midrun_rst_flags", {overflow, timeout}, 0);
    @(negedge pclk);
    de_in = 1'b0;
    reset_n = 1'b1;
    @(negedge pclk);
    continuous = 1'b0;
    do_start();
    r = '{0, 0, 10, 0, 0, 0, 8, 0, 0, 0, 0, 1};
    run_window(r);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
